bp_be_pipe_int_staged: RTL and testbench

- Parametrised, pipelined successor to the single-cycle integer pipe in the BE calculator.
- Computes ALU, branch and jump results, then carries them through a configurable number of register stages before writeback.
- Adds min/max, shift-add and logical-negate ops.
- Adds per-stage flush, so results can be retimed against the longer calculator pipelines.

---
 rtl/bp_be_pipe_int_staged.sv | 193 +++++++++++++++++++
 tb/tb_bp_be_pipe_int_staged.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_pipe_int_staged.sv
// Pipelined integer pipe for the BE calculator: ALU, branch and jump resolution at issue,
// followed by latency_p register stages with per-stage flush ahead of writeback.
module bp_be_pipe_int_staged #(
  parameter int dword_width_p        = 64,
  parameter int vaddr_width_p        = 39,
  parameter int latency_p            = 2,
  parameter int compressed_support_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic                     v_i,
  input  logic [4:0]               fu_op_i,
  input  logic                     word_op_i,
  input  logic                     src1_sel_i,
  input  logic                     src2_sel_i,
  input  logic                     baddr_sel_i,
  input  logic                     branch_v_i,
  input  logic                     jump_v_i,
  input  logic                     compressed_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] rs2_i,
  input  logic [dword_width_p-1:0] imm_i,
  input  logic                     flush_i,
  output logic [dword_width_p-1:0] data_o,
  output logic                     v_o,
  output logic                     branch_o,
  output logic                     btaken_o,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic                     instr_misaligned_v_o
);

  localparam int DW = dword_width_p;
  localparam int VW = vaddr_width_p;
  localparam bit MISALIGN_CHECK = (compressed_support_p == 0);

  if (latency_p < 1 || latency_p > 4) begin : g_latency_check
    $error("bp_be_pipe_int_staged: latency_p must be in 1..4");
  end

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_PASS2  = 5'd8,
    OP_PASS1  = 5'd9,
    OP_PASS0  = 5'd10,
    OP_EQ     = 5'd11,
    OP_NE     = 5'd12,
    OP_SLT    = 5'd13,
    OP_SLTU   = 5'd14,
    OP_SGE    = 5'd15,
    OP_SGEU   = 5'd16,
    OP_MIN    = 5'd17,
    OP_MAX    = 5'd18,
    OP_MINU   = 5'd19,
    OP_MAXU   = 5'd20,
    OP_SH1ADD = 5'd21,
    OP_SH2ADD = 5'd22,
    OP_SH3ADD = 5'd23,
    OP_ANDN   = 5'd24,
    OP_ORN    = 5'd25,
    OP_XNOR   = 5'd26
  } e_fu_op;

  logic [DW-1:0] w_src1;
  logic [DW-1:0] w_src2;
  logic [5:0]    w_shamt;
  logic [DW-1:0] w_src1_srl;
  logic [DW-1:0] w_src1_sra;
  logic          w_eq;
  logic          w_lt;
  logic          w_ltu;
  logic [DW-1:0] w_alu_raw;
  logic [DW-1:0] w_alu;

  assign w_src1  = src1_sel_i ? {{(DW-VW){pc_i[VW-1]}}, pc_i} : rs1_i;
  assign w_src2  = src2_sel_i ? imm_i : rs2_i;
  assign w_shamt = word_op_i ? {1'b0, w_src2[4:0]} : w_src2[5:0];

  // Word right shifts see only the low half, extended to match the shift flavour.
  assign w_src1_srl = word_op_i ? {{(DW-32){1'b0}}, w_src1[31:0]} : w_src1;
  assign w_src1_sra = word_op_i ? {{(DW-32){w_src1[31]}}, w_src1[31:0]} : w_src1;

  assign w_eq  = (w_src1 == w_src2);
  assign w_lt  = ($signed(w_src1) < $signed(w_src2));
  assign w_ltu = (w_src1 < w_src2);

  always_comb begin
    w_alu_raw = '0;
    case (e_fu_op'(fu_op_i))
      OP_ADD:    w_alu_raw = w_src1 + w_src2;
      OP_SUB:    w_alu_raw = w_src1 - w_src2;
      OP_XOR:    w_alu_raw = w_src1 ^ w_src2;
      OP_OR:     w_alu_raw = w_src1 | w_src2;
      OP_AND:    w_alu_raw = w_src1 & w_src2;
      OP_SLL:    w_alu_raw = w_src1 << w_shamt;
      OP_SRL:    w_alu_raw = w_src1_srl >> w_shamt;
      OP_SRA:    w_alu_raw = $unsigned($signed(w_src1_sra) >>> w_shamt);
      OP_PASS2:  w_alu_raw = w_src2;
      OP_PASS1:  w_alu_raw = {{(DW-1){1'b0}}, 1'b1};
      OP_PASS0:  w_alu_raw = '0;
      OP_EQ:     w_alu_raw = {{(DW-1){1'b0}}, w_eq};
      OP_NE:     w_alu_raw = {{(DW-1){1'b0}}, ~w_eq};
      OP_SLT:    w_alu_raw = {{(DW-1){1'b0}}, w_lt};
      OP_SLTU:   w_alu_raw = {{(DW-1){1'b0}}, w_ltu};
      OP_SGE:    w_alu_raw = {{(DW-1){1'b0}}, ~w_lt};
      OP_SGEU:   w_alu_raw = {{(DW-1){1'b0}}, ~w_ltu};
      OP_MIN:    w_alu_raw = w_lt  ? w_src1 : w_src2;
      OP_MAX:    w_alu_raw = w_lt  ? w_src2 : w_src1;
      OP_MINU:   w_alu_raw = w_ltu ? w_src1 : w_src2;
      OP_MAXU:   w_alu_raw = w_ltu ? w_src2 : w_src1;
      OP_SH1ADD: w_alu_raw = (w_src1 << 1) + w_src2;
      OP_SH2ADD: w_alu_raw = (w_src1 << 2) + w_src2;
      OP_SH3ADD: w_alu_raw = (w_src1 << 3) + w_src2;
      OP_ANDN:   w_alu_raw = w_src1 & ~w_src2;
      OP_ORN:    w_alu_raw = w_src1 | ~w_src2;
      OP_XNOR:   w_alu_raw = w_src1 ^ ~w_src2;
      default:   w_alu_raw = '0;
    endcase
  end

  assign w_alu = word_op_i ? {{(DW-32){w_alu_raw[31]}}, w_alu_raw[31:0]} : w_alu_raw;

  logic [VW-1:0] w_base;
  logic [VW-1:0] w_target_sum;
  logic [VW-1:0] w_target;
  logic [VW-1:0] w_ntaken;
  logic          w_taken;
  logic [DW-1:0] w_data;
  logic [VW-1:0] w_npc;
  logic          w_misaligned;

  assign w_base       = baddr_sel_i ? rs1_i[VW-1:0] : pc_i;
  assign w_target_sum = w_base + imm_i[VW-1:0];
  assign w_target     = w_target_sum & ~{{(VW-1){1'b0}}, 1'b1};
  assign w_ntaken     = pc_i + (compressed_i ? VW'(2) : VW'(4));
  assign w_taken      = branch_v_i & (jump_v_i | w_alu[0]);
  // Branches and jumps write the link address to rd.
  assign w_data       = branch_v_i ? {{(DW-VW){w_ntaken[VW-1]}}, w_ntaken} : w_alu;
  assign w_npc        = w_taken ? w_target : w_ntaken;
  assign w_misaligned = w_taken & w_target[1] & MISALIGN_CHECK;

  logic          r_v          [latency_p];
  logic [DW-1:0] r_data       [latency_p];
  logic          r_branch     [latency_p];
  logic          r_btaken     [latency_p];
  logic [VW-1:0] r_npc        [latency_p];
  logic          r_misaligned [latency_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < latency_p; k++) begin
        r_v[k]          <= 1'b0;
        r_data[k]       <= '0;
        r_branch[k]     <= 1'b0;
        r_btaken[k]     <= 1'b0;
        r_npc[k]        <= '0;
        r_misaligned[k] <= 1'b0;
      end
    end else begin
      r_v[0]          <= en_i & v_i & ~flush_i;
      r_data[0]       <= w_data;
      r_branch[0]     <= branch_v_i;
      r_btaken[0]     <= w_taken;
      r_npc[0]        <= w_npc;
      r_misaligned[0] <= w_misaligned;
      // Flush kills every in-flight op; payload still shifts since it is qualified by v.
      for (int k = 1; k < latency_p; k++) begin
        r_v[k]          <= r_v[k-1] & ~flush_i;
        r_data[k]       <= r_data[k-1];
        r_branch[k]     <= r_branch[k-1];
        r_btaken[k]     <= r_btaken[k-1];
        r_npc[k]        <= r_npc[k-1];
        r_misaligned[k] <= r_misaligned[k-1];
      end
    end
  end

  assign v_o                  = r_v[latency_p-1];
  assign data_o               = r_data[latency_p-1];
  assign npc_o                = r_npc[latency_p-1];
  assign branch_o             = r_branch[latency_p-1] & v_o;
  assign btaken_o             = r_btaken[latency_p-1] & v_o;
  assign instr_misaligned_v_o = r_misaligned[latency_p-1] & v_o;

endmodule

// File: tb/tb_bp_be_pipe_int_staged.sv
// Directed bench for bp_be_pipe_int_staged: one instance with compressed targets legal,
// one with them flagged misaligned, both at latency 2 and sharing all inputs.
module tb_bp_be_pipe_int_staged;

  logic        clk = 1'b0;
  logic        reset_i, en_i, v_i, word_op_i, src1_sel_i, src2_sel_i, baddr_sel_i;
  logic        branch_v_i, jump_v_i, compressed_i, flush_i;
  logic [4:0]  fu_op_i;
  logic [38:0] pc_i;
  logic [63:0] rs1_i, rs2_i, imm_i;

  logic [63:0] data_o, nc_data_o;
  logic        v_o, branch_o, btaken_o, mis_o;
  logic        nc_v_o, nc_branch_o, nc_btaken_o, nc_mis_o;
  logic [38:0] npc_o, nc_npc_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bp_be_pipe_int_staged #(.latency_p(2), .compressed_support_p(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .fu_op_i(fu_op_i),
    .word_op_i(word_op_i), .src1_sel_i(src1_sel_i), .src2_sel_i(src2_sel_i),
    .baddr_sel_i(baddr_sel_i), .branch_v_i(branch_v_i), .jump_v_i(jump_v_i),
    .compressed_i(compressed_i), .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .flush_i(flush_i), .data_o(data_o), .v_o(v_o),
    .branch_o(branch_o), .btaken_o(btaken_o), .npc_o(npc_o),
    .instr_misaligned_v_o(mis_o));

  bp_be_pipe_int_staged #(.latency_p(2), .compressed_support_p(0)) dut_nc (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .fu_op_i(fu_op_i),
    .word_op_i(word_op_i), .src1_sel_i(src1_sel_i), .src2_sel_i(src2_sel_i),
    .baddr_sel_i(baddr_sel_i), .branch_v_i(branch_v_i), .jump_v_i(jump_v_i),
    .compressed_i(compressed_i), .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .flush_i(flush_i), .data_o(nc_data_o), .v_o(nc_v_o),
    .branch_o(nc_branch_o), .btaken_o(nc_btaken_o), .npc_o(nc_npc_o),
    .instr_misaligned_v_o(nc_mis_o));

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        word, s1sel, s2sel, bsel, br, jmp, cmp;
    logic [38:0] pc;
    logic [63:0] rs1, rs2, imm;
    logic [63:0] e_data;
    logic        e_bt;
    logic [38:0] e_npc;
    logic        e_mis_nc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t alu_v(string nm, logic [4:0] op, logic word, logic s1sel,
                                 logic s2sel, logic [38:0] pc, logic [63:0] rs1,
                                 logic [63:0] rs2, logic [63:0] imm, logic [63:0] e_data);
    vec_t v;
    v.name = nm; v.op = op; v.word = word; v.s1sel = s1sel; v.s2sel = s2sel;
    v.bsel = 1'b0; v.br = 1'b0; v.jmp = 1'b0; v.cmp = 1'b0;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.e_data = e_data;
    v.e_bt = 1'b0; v.e_npc = pc + 39'd4; v.e_mis_nc = 1'b0;
    return v;
  endfunction

  function automatic vec_t br_v(string nm, logic [4:0] op, logic bsel, logic jmp, logic cmp,
                                logic [38:0] pc, logic [63:0] rs1, logic [63:0] rs2,
                                logic [63:0] imm, logic [63:0] e_data, logic e_bt,
                                logic [38:0] e_npc, logic e_mis_nc);
    vec_t v;
    v.name = nm; v.op = op; v.word = 1'b0; v.s1sel = 1'b0; v.s2sel = 1'b0;
    v.bsel = bsel; v.br = 1'b1; v.jmp = jmp; v.cmp = cmp;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.e_data = e_data;
    v.e_bt = e_bt; v.e_npc = e_npc; v.e_mis_nc = e_mis_nc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    en_i = 1'b0; v_i = 1'b0; flush_i = 1'b0;
    fu_op_i = '0; word_op_i = 1'b0; src1_sel_i = 1'b0; src2_sel_i = 1'b0;
    baddr_sel_i = 1'b0; branch_v_i = 1'b0; jump_v_i = 1'b0; compressed_i = 1'b0;
    pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
  endtask

  task automatic drive(input vec_t v);
    en_i = 1'b1; v_i = 1'b1; flush_i = 1'b0;
    fu_op_i = v.op; word_op_i = v.word; src1_sel_i = v.s1sel; src2_sel_i = v.s2sel;
    baddr_sel_i = v.bsel; branch_v_i = v.br; jump_v_i = v.jmp; compressed_i = v.cmp;
    pc_i = v.pc; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
  endtask

  task automatic issue_add(input logic [63:0] a, input logic [63:0] b);
    idle();
    en_i = 1'b1; v_i = 1'b1; rs1_i = a; rs2_i = b;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".v"}, 64'(v_o), 64'd0);
    chk({nm, ".data"}, data_o, 64'd0);
    chk({nm, ".branch"}, 64'(branch_o), 64'd0);
    chk({nm, ".btaken"}, 64'(btaken_o), 64'd0);
    chk({nm, ".npc"}, 64'(npc_o), 64'd0);
    chk({nm, ".mis"}, 64'(mis_o), 64'd0);
    chk({nm, ".nc_v"}, 64'(nc_v_o), 64'd0);
    chk({nm, ".nc_mis"}, 64'(nc_mis_o), 64'd0);
  endtask

  initial begin
    logic [63:0] all1;
    all1 = '1;
    idle();
    reset_i = 1'b1;

    vecs.push_back(alu_v("add",       5'd0,  0, 0, 0, '0, 64'd5, 64'd7, '0, 64'd12));
    vecs.push_back(alu_v("sub",       5'd1,  0, 0, 0, '0, 64'd5, 64'd7, '0, 64'hFFFF_FFFF_FFFF_FFFE));
    vecs.push_back(alu_v("addw_ovf",  5'd0,  1, 0, 0, '0, 64'h7FFF_FFFF, 64'd1, '0, 64'hFFFF_FFFF_8000_0000));
    vecs.push_back(alu_v("sraw",      5'd7,  1, 0, 0, '0, 64'h8000_0000, 64'd4, '0, 64'hFFFF_FFFF_F800_0000));
    vecs.push_back(alu_v("srlw",      5'd6,  1, 0, 0, '0, 64'hFFFF_FFFF_8000_0000, 64'd4, '0, 64'h0000_0000_0800_0000));
    vecs.push_back(alu_v("sra63",     5'd7,  0, 0, 0, '0, 64'h8000_0000_0000_0000, 64'h3F, '0, all1));
    vecs.push_back(alu_v("min",       5'd17, 0, 0, 0, '0, all1, 64'd1, '0, all1));
    vecs.push_back(alu_v("max",       5'd18, 0, 0, 0, '0, all1, 64'd1, '0, 64'd1));
    vecs.push_back(alu_v("minu",      5'd19, 0, 0, 0, '0, all1, 64'd1, '0, 64'd1));
    vecs.push_back(alu_v("maxu",      5'd20, 0, 0, 0, '0, all1, 64'd1, '0, all1));
    vecs.push_back(alu_v("sh3add",    5'd23, 0, 0, 0, '0, 64'd2, 64'd5, '0, 64'd21));
    vecs.push_back(alu_v("slt",       5'd13, 0, 0, 0, '0, all1, 64'd1, '0, 64'd1));
    vecs.push_back(alu_v("sltu",      5'd14, 0, 0, 0, '0, all1, 64'd1, '0, 64'd0));
    vecs.push_back(alu_v("andn",      5'd24, 0, 0, 0, '0, 64'hF0F0, 64'h00FF, '0, 64'hF000));
    vecs.push_back(alu_v("xnor",      5'd26, 0, 0, 0, '0, 64'd0, 64'd0, '0, all1));
    vecs.push_back(alu_v("pass_one",  5'd9,  0, 0, 0, '0, 64'd77, 64'd88, '0, 64'd1));
    vecs.push_back(alu_v("bad_op",    5'd31, 0, 0, 0, '0, 64'd77, 64'd88, '0, 64'd0));
    vecs.push_back(alu_v("src2_imm",  5'd0,  0, 0, 1, '0, 64'd100, 64'h999, 64'h10, 64'h74));
    vecs.push_back(alu_v("src1_pc",   5'd0,  0, 1, 0, 39'h40_0000_0000, 64'h999, 64'd1, '0,
                         64'hFFFF_FFC0_0000_0001));
    vecs.push_back(br_v("beq_taken",  5'd11, 0, 0, 0, 39'h1000, 64'd3, 64'd3, 64'h20,
                        64'h1004, 1, 39'h1020, 0));
    vecs.push_back(br_v("beq_ntaken", 5'd11, 0, 0, 0, 39'h1000, 64'd3, 64'd4, 64'h20,
                        64'h1004, 0, 39'h1004, 0));
    vecs.push_back(br_v("jal_mis",    5'd0,  0, 1, 0, 39'h1000, 64'd0, 64'd0, 64'h22,
                        64'h1004, 1, 39'h1022, 1));
    vecs.push_back(br_v("jalr_c",     5'd0,  1, 1, 1, 39'h1000, 64'h2001, 64'd0, 64'd4,
                        64'h1002, 1, 39'h2004, 0));
    vecs.push_back(br_v("blt_wrap",   5'd13, 0, 0, 0, 39'h7F_FFFF_FFFC, 64'd5, 64'd3, 64'h40,
                        64'd0, 0, 39'd0, 0));

    // Reset state
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk_all_zero("reset");

    // Latency: visible in exactly one cycle, two cycles after issue
    @(negedge clk); issue_add(64'd5, 64'd7);
    @(negedge clk); chk("lat.t1.v", 64'(v_o), 64'd0); idle();
    @(negedge clk); chk("lat.t2.v", 64'(v_o), 64'd1); chk("lat.t2.data", data_o, 64'd12);
    @(negedge clk); chk("lat.t3.v", 64'(v_o), 64'd0);

    foreach (vecs[i]) begin
      @(negedge clk); drive(vecs[i]);
      @(negedge clk); idle();
      chk({vecs[i].name, ".v_early"}, 64'(v_o), 64'd0);
      @(negedge clk);
      chk({vecs[i].name, ".v"}, 64'(v_o), 64'd1);
      chk({vecs[i].name, ".data"}, data_o, vecs[i].e_data);
      chk({vecs[i].name, ".branch"}, 64'(branch_o), 64'(vecs[i].br));
      chk({vecs[i].name, ".btaken"}, 64'(btaken_o), 64'(vecs[i].e_bt));
      chk({vecs[i].name, ".npc"}, 64'(npc_o), 64'(vecs[i].e_npc));
      chk({vecs[i].name, ".mis"}, 64'(mis_o), 64'd0);
      chk({vecs[i].name, ".nc_mis"}, 64'(nc_mis_o), 64'(vecs[i].e_mis_nc));
      chk({vecs[i].name, ".nc_btaken"}, 64'(nc_btaken_o), 64'(vecs[i].e_bt));
    end

    // Flush in cycle 2 of a four-op burst: op0 survives, op1/op2 die, op3 arrives at cycle 5
    begin
      logic       fl_v [7];
      logic [7:0] fl_d [7];
      fl_v = '{0, 0, 1, 0, 0, 1, 0};
      fl_d = '{0, 0, 1, 0, 0, 4, 0};
      repeat (2) @(negedge clk);
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        chk($sformatf("flush.c%0d.v", c), 64'(v_o), 64'(fl_v[c]));
        chk($sformatf("flush.c%0d.nc_v", c), 64'(nc_v_o), 64'(fl_v[c]));
        if (fl_v[c]) chk($sformatf("flush.c%0d.data", c), data_o, 64'(fl_d[c]));
        if (c < 4) begin
          issue_add(64'(c + 1), 64'd0);
          flush_i = (c == 2);
        end else begin
          idle();
        end
      end
    end

    // Back-to-back issues arrive in order, one per cycle
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("b2b.c%0d.v", c), 64'(v_o), 64'd1);
        chk($sformatf("b2b.c%0d.data", c), data_o, 64'(10 + c - 2));
      end else begin
        chk($sformatf("b2b.c%0d.v", c), 64'(v_o), 64'd0);
      end
      if (c < 3) issue_add(64'(10 + c), 64'd0);
      else idle();
    end

    // Reset with two ops in flight, and an issue coinciding with reset
    @(negedge clk); issue_add(64'd1, 64'd1);
    @(negedge clk); drive(vecs[21]);
    @(negedge clk);
    chk("rst_mid.c2.v", 64'(v_o), 64'd1);
    chk("rst_mid.c2.data", data_o, 64'd2);
    issue_add(64'd9, 64'd9);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; idle();
    chk_all_zero("rst_mid.c3");
    @(negedge clk);
    chk("rst_mid.c4.v", 64'(v_o), 64'd0);
    chk("rst_mid.c4.nc_v", 64'(nc_v_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
